sram_controller: RTL and testbench

//  Sits directly downstream of the MEM stage of the 5-stage pipeline and replaces its single-cycle data memory.
//  It turns one 32-bit load/store request into two 16-bit accesses on an external asynchronous SRAM.

---
 rtl/sram_controller_if.sv | 28 ++
 rtl/sram_controller.sv | 115 +++++++++++
 tb/tb_sram_controller.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/sram_controller_if.sv
// Pipeline-side and SRAM-side signals of the 32-bit-over-16-bit SRAM bridge.
// The controller uses the slave view; the pipeline/pad environment uses the master view.
interface sram_controller_if #(
  parameter int SRAM_ADDR_W = 18
);
  logic                   wr_en;
  logic                   rd_en;
  logic [31:0]            address;
  logic [31:0]            write_data;
  logic [31:0]            read_data;
  logic                   ready;
  logic [SRAM_ADDR_W-1:0] sram_addr;
  logic [15:0]            sram_dq_out;
  logic [15:0]            sram_dq_in;
  logic                   sram_dq_oe;
  logic                   sram_we_n;
  logic                   sram_oe_n;

  modport master (
    output wr_en, rd_en, address, write_data, sram_dq_in,
    input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, sram_oe_n
  );

  modport slave (
    input  wr_en, rd_en, address, write_data, sram_dq_in,
    output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, sram_oe_n
  );
endinterface

// File: rtl/sram_controller.sv
// Splits each 32-bit load/store from MEM into two 16-bit async-SRAM accesses,
// holding ready low (pipeline freeze) until the access sequence completes.
module sram_controller #(
  parameter int BASE_ADDR   = 1024,
  parameter int SRAM_ADDR_W = 18,
  parameter int ACCESS_CYC  = 5
) (
  input  logic             clock,
  input  logic             reset,
  sram_controller_if.slave bus
);

  localparam int WORD_W   = SRAM_ADDR_W - 1;
  localparam int WAIT_CYC = ACCESS_CYC - 3;
  localparam int CW       = (ACCESS_CYC > 2) ? $clog2(ACCESS_CYC) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOW, S_HIGH, S_WAIT, S_DONE} state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [CW-1:0]          r_wait_cnt;
  logic                   r_is_wr;
  logic [WORD_W-1:0]      r_word;
  logic [15:0]            r_wdata_hi;
  logic [31:0]            r_rdata;
  logic [SRAM_ADDR_W-1:0] r_sram_addr;
  logic [15:0]            r_dq_out;

  logic                   w_req;
  logic                   w_wait_last;
  logic [WORD_W-1:0]      w_word;
  logic                   w_active;
  logic                   w_ready;
  logic                   w_we_n;
  logic                   w_oe_n;
  logic                   w_dq_oe;

  assign w_req       = bus.rd_en | bus.wr_en;
  assign w_wait_last = (r_wait_cnt == CW'(WAIT_CYC - 1));
  // Out-of-range addresses simply wrap inside the SRAM word space.
  assign w_word      = WORD_W'((bus.address - 32'(BASE_ADDR)) >> 2);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_req) w_next = S_LOW;
      S_LOW:  w_next = S_HIGH;
      S_HIGH: w_next = (WAIT_CYC == 0) ? S_DONE : S_WAIT;
      S_WAIT: if (w_wait_last) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Strobes decode straight from state so an async reset drops them at once.
  always_comb begin
    w_active = (r_state == S_LOW) || (r_state == S_HIGH);
    w_ready  = 1'b0;
    case (r_state)
      S_IDLE:  w_ready = ~w_req;
      S_DONE:  w_ready = 1'b1;
      default: w_ready = 1'b0;
    endcase
    w_we_n  = ~(w_active &  r_is_wr);
    w_oe_n  = ~(w_active & ~r_is_wr);
    w_dq_oe =   w_active &  r_is_wr;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wait_cnt  <= '0;
      r_is_wr     <= 1'b0;
      r_word      <= '0;
      r_wdata_hi  <= '0;
      r_rdata     <= '0;
      r_sram_addr <= '0;
      r_dq_out    <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_req) begin
          r_is_wr     <= bus.wr_en;
          r_word      <= w_word;
          r_wdata_hi  <= bus.write_data[31:16];
          r_sram_addr <= {w_word, 1'b0};
          if (bus.wr_en) r_dq_out <= bus.write_data[15:0];
        end
        S_LOW: begin
          r_sram_addr <= {r_word, 1'b1};
          if (r_is_wr) r_dq_out     <= r_wdata_hi;
          else         r_rdata[15:0] <= bus.sram_dq_in;
        end
        S_HIGH: begin
          if (!r_is_wr) r_rdata[31:16] <= bus.sram_dq_in;
          r_wait_cnt <= '0;
        end
        S_WAIT: r_wait_cnt <= r_wait_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.ready       = w_ready;
  assign bus.read_data   = r_rdata;
  assign bus.sram_addr   = r_sram_addr;
  assign bus.sram_dq_out = r_dq_out;
  assign bus.sram_dq_oe  = w_dq_oe;
  assign bus.sram_we_n   = w_we_n;
  assign bus.sram_oe_n   = w_oe_n;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: half-word SRAM pad model, transaction-level reference
// model compared every cycle, plus hand-computed literal expectations.
module tb_sram_controller;
  localparam int ACC = 5;
  localparam int AW  = 18;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  sram_controller_if #(.SRAM_ADDR_W(AW)) bus();

  sram_controller #(.BASE_ADDR(1024), .SRAM_ADDR_W(AW), .ACCESS_CYC(ACC)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Pad-level SRAM: written while we_n is low, read while oe_n is low.
  logic [15:0] sram [0:(1<<AW)-1];
  initial begin
    for (int j = 0; j < (1 << AW); j++) sram[j] = 16'h0;
    forever begin
      @(negedge clock);
      if (!bus.sram_we_n && bus.sram_dq_oe) sram[bus.sram_addr] = bus.sram_dq_out;
    end
  end
  always_comb bus.sram_dq_in = !bus.sram_oe_n ? sram[bus.sram_addr] : 16'hA5A5;

  // Reference model: m_k = cycle index within the current access, -1 when idle.
  logic [15:0] m_half [0:(1<<AW)-1];
  int          m_k    = -1;
  bit          m_wr   = 1'b0;
  int unsigned m_word = 0;
  logic [31:0] m_data = '0;
  logic [31:0] e_rdata = '0;
  logic [AW-1:0] e_addr = '0;
  logic [15:0] e_dq = '0;

  function automatic int unsigned word_of(input logic [31:0] a);
    return ((a - 32'd1024) >> 2) & ((32'd1 << (AW - 1)) - 1);
  endfunction

  initial begin
    int h;
    int unsigned ha;
    for (int j = 0; j < (1 << AW); j++) m_half[j] = 16'h0;
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) begin
        m_k = -1; m_wr = 1'b0; m_word = 0; m_data = '0;
        e_rdata = '0; e_addr = '0; e_dq = '0;
      end else if (m_k < 0) begin
        if (bus.wr_en || bus.rd_en) begin
          m_k    = 1;
          m_wr   = bus.wr_en;
          m_word = word_of(bus.address);
          m_data = bus.write_data;
          e_addr = AW'(m_word * 2);
          if (m_wr) e_dq = m_data[15:0];
        end
      end else if (m_k == 1 || m_k == 2) begin
        h  = m_k - 1;
        ha = m_word * 2 + h;
        if (m_wr) m_half[ha] = m_data[16*h +: 16];
        else      e_rdata[16*h +: 16] = m_half[ha];
        if (m_k == 1) begin
          e_addr = AW'(m_word * 2 + 1);
          if (m_wr) e_dq = m_data[31:16];
        end
        m_k++;
      end else if (m_k == ACC) begin
        m_k = -1;
      end else begin
        m_k++;
      end
    end
  end

  bit act;
  bit e_rdy;
  initial forever begin
    @(negedge clock);
    if (chk_en) begin
      act   = (m_k == 1 || m_k == 2);
      e_rdy = (m_k < 0) ? !(bus.wr_en || bus.rd_en) : (m_k == ACC);
      chk("ready",     32'(bus.ready),      32'(e_rdy));
      chk("we_n",      32'(bus.sram_we_n),  32'(!(act && m_wr)));
      chk("oe_n",      32'(bus.sram_oe_n),  32'(!(act && !m_wr)));
      chk("dq_oe",     32'(bus.sram_dq_oe), 32'(act && m_wr));
      chk("sram_addr", 32'(bus.sram_addr),  32'(e_addr));
      chk("read_data", bus.read_data,       e_rdata);
      if (act && m_wr) chk("dq_out", 32'(bus.sram_dq_out), 32'(e_dq));
    end
  end

  // Per-cycle snapshots of the most recent access (index = cycle from request).
  logic [AW-1:0] s_addr [0:ACC];
  logic [15:0]   s_dq   [0:ACC];
  logic          s_we   [0:ACC];
  logic          s_oe   [0:ACC];
  logic          s_rdy  [0:ACC];
  logic [31:0]   s_rd   [0:ACC];

  // Called at posedge+2; returns at posedge+2 after the edge that ends DONE,
  // with the request dropped. Address/data are scrambled mid-access.
  task automatic access(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d);
    bus.wr_en = wr; bus.rd_en = rd; bus.address = a; bus.write_data = d;
    for (int c = 0; c <= ACC; c++) begin
      @(negedge clock);
      s_addr[c] = bus.sram_addr; s_dq[c] = bus.sram_dq_out; s_we[c] = bus.sram_we_n;
      s_oe[c] = bus.sram_oe_n; s_rdy[c] = bus.ready; s_rd[c] = bus.read_data;
      if (c == 1) begin
        bus.address    = a ^ 32'h40;
        bus.write_data = ~d;
      end
    end
    @(posedge clock); #2;
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
  endtask

  task automatic chk_timing(input string nm);
    for (int c = 0; c < ACC; c++) chk({nm, "_rdy_low"}, 32'(s_rdy[c]), 32'd0);
    chk({nm, "_rdy_done"}, 32'(s_rdy[ACC]), 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #2; end
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.address = '0; bus.write_data = '0;
    #1;
    chk("rst_we_n",  32'(bus.sram_we_n),  32'd1);
    chk("rst_oe_n",  32'(bus.sram_oe_n),  32'd1);
    chk("rst_dq_oe", 32'(bus.sram_dq_oe), 32'd0);
    chk("rst_addr",  32'(bus.sram_addr),  32'd0);
    chk("rst_rdata", bus.read_data,       32'd0);
    chk("rst_ready", 32'(bus.ready),      32'd1);
    chk_en = 1'b1;
    repeat (2) @(posedge clock);
    #2 reset = 1'b1;
    idle(1);

    // Write 0xDEADBEEF @1024
    access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF);
    chk("wr_addr_lo", 32'(s_addr[1]), 32'd0);
    chk("wr_dq_lo",   32'(s_dq[1]),   32'h0000BEEF);
    chk("wr_we_lo",   32'(s_we[1]),   32'd0);
    chk("wr_addr_hi", 32'(s_addr[2]), 32'd1);
    chk("wr_dq_hi",   32'(s_dq[2]),   32'h0000DEAD);
    chk_timing("wr1");
    chk("sram0", 32'(sram[0]), 32'h0000BEEF);
    chk("sram1", 32'(sram[1]), 32'h0000DEAD);
    idle(1);

    // Read it back
    access(1'b0, 1'b1, 32'd1024, 32'h0);
    chk("rd_data_done", s_rd[ACC], 32'hDEADBEEF);
    for (int c = 0; c <= ACC; c++) chk("rd_we_n_idle", 32'(s_we[c]), 32'd1);
    chk("rd_oe_lo",  32'(s_oe[1]), 32'd0);
    chk("rd_oe_hi",  32'(s_oe[2]), 32'd0);
    chk("rd_oe_off", 32'(s_oe[3]), 32'd1);
    chk_timing("rd1");

    // rd_en and wr_en together act as a write only
    access(1'b1, 1'b1, 32'd1028, 32'h12345678);
    chk("both_sram2", 32'(sram[2]), 32'h00005678);
    chk("both_sram3", 32'(sram[3]), 32'h00001234);
    chk("both_rdata", bus.read_data, 32'hDEADBEEF);

    // Address mapping, including wrap below BASE_ADDR
    access(1'b0, 1'b1, 32'd1036, 32'h0);
    chk("map_1036_lo", 32'(s_addr[1]), 32'd6);
    chk("map_1036_hi", 32'(s_addr[2]), 32'd7);
    access(1'b0, 1'b1, 32'd1020, 32'h0);
    chk("wrap_lo", 32'(s_addr[1]), 32'h3FFFE);
    chk("wrap_hi", 32'(s_addr[2]), 32'h3FFFF);
    idle(2);

    // Back-to-back read then write; mid-access address changes ignored
    access(1'b0, 1'b1, 32'd1028, 32'h0);
    chk("b2b_rdata", bus.read_data, 32'h12345678);
    chk_timing("b2b_rd");
    access(1'b1, 1'b0, 32'd1040, 32'hCAFEF00D);
    chk_timing("b2b_wr");
    chk("b2b_sram8",  32'(sram[8]),  32'h0000F00D);
    chk("b2b_sram9",  32'(sram[9]),  32'h0000CAFE);
    chk("b2b_sram40", 32'(sram[40]), 32'h0);
    idle(1);
    access(1'b0, 1'b1, 32'd1040, 32'h0);
    chk("b2b_readback", bus.read_data, 32'hCAFEF00D);
    idle(1);

    // Reset during HIGH of a write
    bus.wr_en = 1'b1; bus.address = 32'd1044; bus.write_data = 32'h11112222;
    @(posedge clock); @(posedge clock); #2;
    reset = 1'b0;
    #1;
    chk("arst_we_n",  32'(bus.sram_we_n),  32'd1);
    chk("arst_dq_oe", 32'(bus.sram_dq_oe), 32'd0);
    chk("arst_ready_req", 32'(bus.ready),  32'd0);
    chk("arst_rdata", bus.read_data,       32'd0);
    bus.wr_en = 1'b0;
    #1;
    chk("arst_ready_idle", 32'(bus.ready), 32'd1);
    @(posedge clock); #2 reset = 1'b1;
    chk("arst_sram10", 32'(sram[10]), 32'h00002222);
    chk("arst_sram11", 32'(sram[11]), 32'h0);
    idle(1);
    access(1'b0, 1'b1, 32'd1044, 32'h0);
    chk("arst_readback", bus.read_data, 32'h00002222);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
